alu_result_collector: RTL and testbench

ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

---
 rtl/tinyalu_pkg.sv | 20 ++
 rtl/alu_result_fifo.sv | 56 +++++
 rtl/alu_result_collector.sv | 135 +++++++++++++
 tb/tb_alu_result_collector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// Shared defaults and the result record layout for the ALU result collector.
package tinyalu_pkg;

    localparam int unsigned DEF_RESULT_W = 16;
    localparam int unsigned DEF_CHANNELS = 2;
    localparam int unsigned DEF_DEPTH    = 8;

    function automatic int unsigned chan_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_CH_W = chan_width(DEF_CHANNELS);

    // FIFO entries are packed as {chan, result}, matching this record.
    typedef struct packed {
        logic [DEF_CH_W-1:0]     chan;
        logic [DEF_RESULT_W-1:0] result;
    } result_rec_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Power-of-two FIFO with occupancy count; push while full is legal when popping.
module alu_result_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/alu_result_collector.sv
// Collects per-channel ALU results into hold registers and funnels them
// round-robin into a single output FIFO, tracking dropped results.
module alu_result_collector
    import tinyalu_pkg::*;
#(
    parameter int unsigned RESULT_W = DEF_RESULT_W,
    parameter int unsigned CHANNELS = DEF_CHANNELS,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    localparam int unsigned CH_W    = chan_width(CHANNELS),
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CHANNELS-1:0]          done,
    input  logic [CHANNELS*RESULT_W-1:0] result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [RESULT_W-1:0]          out_result,
    output logic [CH_W-1:0]              out_chan,
    output logic [CNT_W-1:0]             fill_level,
    output logic                         overflow,
    output logic [7:0]                   drop_count,
    input  logic                         clear_err
);

    localparam int unsigned REC_W = CH_W + RESULT_W;

    logic [CHANNELS-1:0] hold_valid_q;
    logic [RESULT_W-1:0] hold_data_q [CHANNELS];
    logic [CH_W-1:0]     rr_last_q;
    logic                overflow_q;
    logic [7:0]          drop_count_q;

    logic                grant_any;
    logic [CH_W-1:0]     grant_idx;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [CHANNELS-1:0] granted;
    logic [CHANNELS-1:0] drop_vec;
    logic [3:0]          n_drops;
    logic [8:0]          drop_sum;
    logic [REC_W-1:0]    wdata;
    logic [REC_W-1:0]    rdata;

    // Search starts one past the last granted channel.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned off = 1; off <= CHANNELS; off++) begin
            idx = (32'(rr_last_q) + off) % CHANNELS;
            if (!grant_any && hold_valid_q[CH_W'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
    end

    assign pop   = !empty && out_ready;
    assign push  = grant_any && (!full || pop);
    assign wdata = {grant_idx, hold_data_q[grant_idx]};

    always_comb begin
        n_drops = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            granted[i]  = push && (grant_idx == CH_W'(i));
            drop_vec[i] = done[i] && hold_valid_q[i] && !granted[i];
            n_drops     = n_drops + 4'(drop_vec[i]);
        end
        drop_sum = {1'b0, drop_count_q} + {5'b0, n_drops};
    end

    // A granted hold frees its slot this edge, so a same-cycle done refills it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                hold_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (done[i] && (!hold_valid_q[i] || granted[i])) begin
                    hold_valid_q[i] <= 1'b1;
                    hold_data_q[i]  <= result[i*RESULT_W +: RESULT_W];
                end else if (granted[i]) begin
                    hold_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_q    <= CH_W'(CHANNELS - 1);
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            if (push) begin
                rr_last_q <= grant_idx;
            end
            if (clear_err) begin
                overflow_q   <= 1'b0;
                drop_count_q <= '0;
            end else if (|drop_vec) begin
                overflow_q   <= 1'b1;
                drop_count_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end
        end
    end

    alu_result_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (wdata),
        .pop     (pop),
        .rdata   (rdata),
        .full    (full),
        .empty   (empty),
        .count   (fill_level)
    );

    assign out_valid  = !empty;
    assign out_result = empty ? '0 : rdata[RESULT_W-1:0];
    assign out_chan   = empty ? '0 : rdata[REC_W-1:RESULT_W];
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector: directed vector table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_alu_result_collector;
    import tinyalu_pkg::*;

    localparam int unsigned RW    = 16;
    localparam int unsigned CH    = 2;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [CH-1:0] done = '0;
    logic [CH*RW-1:0] result = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_result;
    logic [0:0]    out_chan;
    logic [3:0]    fill_level;
    logic          overflow;
    logic [7:0]    drop_count;
    logic          clear_err = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_result_collector #(
        .RESULT_W (RW),
        .CHANNELS (CH),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .done       (done),
        .result     (result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_chan   (out_chan),
        .fill_level (fill_level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clear_err  (clear_err)
    );

    // Reference model state
    result_rec_t mq[$];
    bit          m_hv[CH];
    logic [RW-1:0] m_hd[CH];
    int          m_last;
    int          m_drops;
    bit          m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int c = 0; c < CH; c++) begin
            m_hv[c] = 1'b0;
            m_hd[c] = '0;
        end
        m_last  = CH - 1;
        m_drops = 0;
        m_ovf   = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        bit pop;
        bit acc;
        int g;
        int nd;
        result_rec_t rec;
        pop = (mq.size() > 0) && out_ready;
        g = -1;
        for (int off = 1; off <= CH; off++) begin
            int c;
            c = (m_last + off) % CH;
            if (g < 0 && m_hv[c]) g = c;
        end
        acc = (mq.size() < DEPTH) || pop;
        if (pop) void'(mq.pop_front());
        if (g >= 0 && acc) begin
            rec.result = m_hd[g];
            rec.chan   = 1'(g);
            mq.push_back(rec);
            m_last  = g;
            m_hv[g] = 1'b0;
        end
        nd = 0;
        for (int c = 0; c < CH; c++) begin
            if (done[c]) begin
                if (m_hv[c]) begin
                    nd++;
                end else begin
                    m_hv[c] = 1'b1;
                    m_hd[c] = result[c*RW +: RW];
                end
            end
        end
        if (clear_err) begin
            m_drops = 0;
            m_ovf   = 1'b0;
        end else if (nd > 0) begin
            m_ovf   = 1'b1;
            m_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;
        end
    endtask

    task automatic compare_model();
        check("model_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("model_fill", 32'(fill_level), 32'(mq.size()));
        check("model_overflow", 32'(overflow), 32'(m_ovf));
        check("model_drop_count", 32'(drop_count), 32'(m_drops));
        if (mq.size() != 0) begin
            check("model_result", 32'(out_result), 32'(mq[0].result));
            check("model_chan", 32'(out_chan), 32'(mq[0].chan));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic set_in(input logic [1:0] d, input logic [15:0] r0, input logic [15:0] r1,
                          input logic rdy, input logic clr);
        done      = d;
        result    = {r1, r0};
        out_ready = rdy;
        clear_err = clr;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_fill", 32'(fill_level), 32'd0);
        check("reset_result", 32'(out_result), 32'd0);
        check("reset_chan", 32'(out_chan), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_drop_count", 32'(drop_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        set_in(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  d;
        logic [15:0] r0;
        logic [15:0] r1;
        logic        rdy;
        logic        exp_valid;
        logic [15:0] exp_res;
        logic        exp_ch;
        logic [3:0]  exp_fill;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Single result, then one on channel 1, then simultaneous done on both.
        vecs[0]  = '{2'b01, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};
        vecs[1]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 4'd1};
        vecs[2]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};
        vecs[3]  = '{2'b10, 16'h0000, 16'h5678, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};
        vecs[4]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h5678, 1'b1, 4'd1};
        vecs[5]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};
        vecs[6]  = '{2'b11, 16'h00AA, 16'h00BB, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0};
        vecs[7]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h00AA, 1'b0, 4'd1};
        vecs[8]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h00AA, 1'b0, 4'd2};
        vecs[9]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h00BB, 1'b1, 4'd1};
        vecs[10] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0};

        model_reset();
        do_reset();

        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i].d, vecs[i].r0, vecs[i].r1, vecs[i].rdy, 1'b0);
            tick();
            check("vec_valid", 32'(out_valid), 32'(vecs[i].exp_valid));
            check("vec_fill", 32'(fill_level), 32'(vecs[i].exp_fill));
            check("vec_overflow", 32'(overflow), 32'd0);
            if (vecs[i].exp_valid) begin
                check("vec_result", 32'(out_result), 32'(vecs[i].exp_res));
                check("vec_chan", 32'(out_chan), 32'(vecs[i].exp_ch));
            end
        end

        // Full FIFO: ten back-to-back results on channel 0 with the consumer stalled.
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            set_in(2'b01, 16'(16'h0100 + n), 16'h0, 1'b0, 1'b0);
            tick();
        end
        check("full_fill", 32'(fill_level), 32'd8);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_drop_count", 32'(drop_count), 32'd1);
        check("full_head", 32'(out_result), 32'h0101);

        // Push and pop together while full: hold (9th value) enters as head leaves.
        set_in(2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        check("fullpp_fill", 32'(fill_level), 32'd8);
        for (int k = 2; k <= 9; k++) begin
            check("fullpp_order", 32'(out_result), 32'(16'h0100 + k));
            tick();
        end
        check("fullpp_empty", 32'(out_valid), 32'd0);

        // Saturation: both channels stuck full for long enough to drop >300 results.
        set_in(2'b11, 16'hCAFE, 16'hBEEF, 1'b0, 1'b0);
        repeat (170) tick();
        check("sat_drop_count", 32'(drop_count), 32'd255);
        check("sat_overflow", 32'(overflow), 32'd1);
        set_in(2'b11, 16'hCAFE, 16'hBEEF, 1'b0, 1'b1);
        tick();
        check("clear_drop_count", 32'(drop_count), 32'd0);
        check("clear_overflow", 32'(overflow), 32'd0);
        set_in(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        check("clear_hold_drop_count", 32'(drop_count), 32'd0);

        // Reset mid-stream with five entries queued and one held.
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            set_in(2'b01, 16'(16'h0200 + n), 16'h0, 1'b0, 1'b0);
            tick();
        end
        check("mid_fill", 32'(fill_level), 32'd5);
        set_in(2'b01, 16'h0299, 16'h0, 1'b0, 1'b0);
        do_reset();
        set_in(2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        repeat (4) tick();
        check("mid_no_stale", 32'(out_valid), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            set_in(2'($urandom), 16'($urandom), 16'($urandom),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
